// File: rtl/g_matrix_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : g_matrix_scheduler_if
// Desc     : Source, calculator and status signals of the G-matrix scheduler.
// Revision : 1.0
// ============================================================================
interface g_matrix_scheduler_if #(
  parameter int N       = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
);
  logic [NUM_REQ-1:0]   req;
  logic [NUM_REQ-1:0]   grant;
  logic                 src_rd;
  logic [2:0]           src_idx;
  logic [NUM_REQ*N-1:0] src_r_bus;
  logic [NUM_REQ*N-1:0] src_i_bus;
  logic                 Hq_out_valid;
  logic signed [N-1:0]  Hq_out_r;
  logic signed [N-1:0]  Hq_out_i;
  logic                 G_valid;
  logic                 dn_ready;
  logic                 busy;
  logic                 done;
  logic [ID_W-1:0]      done_id;
  logic                 err;

  modport master (
    input  req, src_r_bus, src_i_bus, G_valid, dn_ready,
    output grant, src_rd, src_idx, Hq_out_valid, Hq_out_r, Hq_out_i,
           busy, done, done_id, err
  );

  modport slave (
    output req, src_r_bus, src_i_bus, G_valid, dn_ready,
    input  grant, src_rd, src_idx, Hq_out_valid, Hq_out_r, Hq_out_i,
           busy, done, done_id, err
  );
endinterface
`default_nettype wire

// File: rtl/g_matrix_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : g_matrix_scheduler
// Desc     : Round-robin sharing of one G calculator between NUM_REQ Hq sources.
// Revision : 1.0
// ============================================================================
module g_matrix_scheduler #(
  parameter int N       = 16,
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int TIMEOUT = 31
) (
  input wire clk,
  input wire rst,
  g_matrix_scheduler_if.master bus
);
  localparam int              c_TW       = $clog2(TIMEOUT + 1);
  localparam logic [c_TW-1:0] c_TMR_LAST = c_TW'(TIMEOUT - 1);
  localparam logic [ID_W-1:0] c_LAST_ID  = ID_W'(NUM_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ARB    = 3'd1,
    S_LOAD   = 3'd2,
    S_DRAIN  = 3'd3,
    S_WAIT_G = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ID_W-1:0]     r_ptr;
  logic [ID_W-1:0]     r_gid;
  logic [ID_W-1:0]     w_pick;
  logic [ID_W-1:0]     w_cand;
  logic [ID_W-1:0]     w_gid_inc;
  logic                w_found;
  logic [NUM_REQ-1:0]  r_grant;
  logic [2:0]          r_idx;
  logic                r_drn;
  logic [c_TW-1:0]     r_tmr;
  logic [2:0]          r_gcnt;
  logic                r_rd_d1;
  logic                r_vld;
  logic                r_err;
  logic signed [N-1:0] r_hq_r;
  logic signed [N-1:0] r_hq_i;
  logic                w_g4;
  logic                w_tmo;
  logic                w_release;

  // First requester at or after the round-robin pointer, wrapping modulo NUM_REQ
  always_comb begin
    int s;
    s       = 0;
    w_found = 1'b0;
    w_pick  = '0;
    w_cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      s = int'(r_ptr) + k;
      if (s >= NUM_REQ) s = s - NUM_REQ;
      w_cand = ID_W'(s);
      if (!w_found && bus.req[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_gid_inc = (r_gid == c_LAST_ID) ? '0 : r_gid + 1'b1;
  assign w_g4      = (r_gcnt == 3'd4) || ((r_gcnt == 3'd3) && bus.G_valid);
  assign w_tmo     = (r_tmr == c_TMR_LAST);
  // Block ends either by completion or by WAIT_G timeout; both free the grant
  assign w_release = (r_state == S_WAIT_G) && (w_g4 || w_tmo);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next           = r_state;
    bus.src_rd       = 1'b0;
    bus.src_idx      = r_idx;
    bus.busy         = (r_state != S_IDLE);
    bus.done         = 1'b0;
    bus.done_id      = '0;
    bus.err          = r_err;
    bus.grant        = r_grant;
    bus.Hq_out_valid = r_vld;
    bus.Hq_out_r     = r_hq_r;
    bus.Hq_out_i     = r_hq_i;
    case (r_state)
      S_IDLE:   if ((|bus.req) && bus.dn_ready) w_next = S_ARB;
      S_ARB:    w_next = w_found ? S_LOAD : S_IDLE;
      S_LOAD: begin
        bus.src_rd = 1'b1;
        if (r_idx == 3'd7) w_next = S_DRAIN;
      end
      S_DRAIN:  if (r_drn) w_next = S_WAIT_G;
      S_WAIT_G: begin
        if (w_g4)       w_next = S_DONE;
        else if (w_tmo) w_next = S_IDLE;
      end
      S_DONE: begin
        bus.done    = 1'b1;
        bus.done_id = r_gid;
        w_next      = S_IDLE;
      end
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr   <= '0;
      r_gid   <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_drn   <= 1'b0;
      r_tmr   <= '0;
      r_gcnt  <= '0;
      r_rd_d1 <= 1'b0;
      r_vld   <= 1'b0;
      r_err   <= 1'b0;
      r_hq_r  <= '0;
      r_hq_i  <= '0;
    end else begin
      // Source answers one cycle after the strobe; register its word on that cycle
      r_rd_d1 <= (r_state == S_LOAD);
      r_vld   <= r_rd_d1;
      if (r_rd_d1) begin
        r_hq_r <= bus.src_r_bus[r_gid*N +: N];
        r_hq_i <= bus.src_i_bus[r_gid*N +: N];
      end
      r_idx <= (r_state == S_LOAD) ? r_idx + 3'd1 : 3'd0;
      r_drn <= (r_state == S_DRAIN) && !r_drn;
      r_tmr <= (r_state == S_WAIT_G) ? r_tmr + 1'b1 : '0;
      r_err <= (r_state == S_WAIT_G) && !w_g4 && w_tmo;

      if (r_state == S_ARB) begin
        r_gcnt <= '0;
      end else if (((r_state == S_DRAIN) || (r_state == S_WAIT_G)) &&
                   bus.G_valid && (r_gcnt != 3'd4)) begin
        r_gcnt <= r_gcnt + 3'd1;
      end

      if ((r_state == S_ARB) && w_found) begin
        r_gid   <= w_pick;
        r_grant <= {{(NUM_REQ-1){1'b0}}, 1'b1} << w_pick;
      end else if (w_release) begin
        r_grant <= '0;
        r_ptr   <= w_gid_inc;
      end
    end
  end
endmodule
`default_nettype wire
